// File: rtl/nw_pkg.sv
// Shared types and constants for the alignment-grid controller.
// The state typedef, the traceback direction codes and the grid reset length
// live here so the controller and any grid-side logic agree on them.
package nw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Traceback direction codes written by the grid alongside each {x,y} step
    localparam logic [1:0] DIR_TOP    = 2'b00;
    localparam logic [1:0] DIR_LEFT   = 2'b01;
    localparam logic [1:0] DIR_CORNER = 2'b10;

    // Number of cycles the grid is held in reset before a job starts
    localparam int LOAD_CYCLES = 2;

endpackage

// File: rtl/nw_rr_arb.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
// The requester granted most recently gets the lowest priority next time.
// The pointer resets to 1 so requester 0 wins the first contested grant.
module nw_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic last_q;
    logic last_d;

    // Pick a winner only when enabled; the pointer only moves on a real grant
    always_comb begin
        gnt_o     = 2'b00;
        gnt_idx_o = 1'b0;
        last_d    = last_q;
        if (en_i) begin
            if (req_i[0] && (!req_i[1] || last_q)) begin
                gnt_o     = 2'b01;
                gnt_idx_o = 1'b0;
                last_d    = 1'b0;
            end else if (req_i[1]) begin
                gnt_o     = 2'b10;
                gnt_idx_o = 1'b1;
                last_d    = 1'b1;
            end
        end
    end

    // Remember who was granted last
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/nw_grid_ctrl.sv
// Job controller for a Needleman-Wunsch alignment grid.
// Accepts jobs from two requesters round-robin, resets the grid for a fixed
// number of cycles, counts traceback steps while the grid runs and presents
// a result that is held until consumed.
// Optional feature: define NW_CTRL_TIMEOUT_EN to abort a job that runs for
// more than TIMEOUT+1 cycles; without it the controller waits forever and
// carries no cycle counter.
module nw_grid_ctrl
    import nw_pkg::*;
#(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int CORD_LENGTH = 8,
    parameter int TIMEOUT     = 1023
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req0_valid,
    input  logic                       req1_valid,
    output logic                       req0_ready,
    output logic                       req1_ready,
    input  logic [LENGTH*CWIDTH-1:0]   req0_s1,
    input  logic [LENGTH*CWIDTH-1:0]   req0_s2,
    input  logic [LENGTH*CWIDTH-1:0]   req1_s1,
    input  logic [LENGTH*CWIDTH-1:0]   req1_s2,
    output logic                       grid_reset,
    output logic [LENGTH*CWIDTH-1:0]   grid_s1,
    output logic [LENGTH*CWIDTH-1:0]   grid_s2,
    input  logic                       grid_valid,
    input  logic                       trace_wen,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       res_id,
    output logic [CORD_LENGTH:0]       res_steps,
    output logic                       res_timeout
);

    localparam int SW  = LENGTH * CWIDTH;
    localparam int STW = CORD_LENGTH + 1;
    localparam logic [STW-1:0] STEPS_MAX     = '1;
    localparam logic [1:0]     LOAD_CNT_LAST = 2'(LOAD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       load_cnt_q, load_cnt_d;
    logic [STW-1:0]   steps_q, steps_d;
    logic             id_q, id_d;
    logic [SW-1:0]    s1_q, s1_d;
    logic [SW-1:0]    s2_q, s2_d;
    logic             arb_en;
    logic [1:0]       gnt;
    logic             gnt_idx;

`ifdef NW_CTRL_TIMEOUT_EN
    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);
    logic [9:0]       cyc_q, cyc_d;
    logic             to_q, to_d;
`endif

    nw_rr_arb u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     ({req1_valid, req0_valid}),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Next-state and datapath updates for the job FSM
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        steps_d    = steps_q;
        id_d       = id_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        arb_en     = 1'b0;
`ifdef NW_CTRL_TIMEOUT_EN
        cyc_d      = cyc_q;
        to_d       = to_q;
`endif
        case (state_q)
            IDLE: begin
                arb_en = 1'b1;
                if (|gnt) begin
                    state_d    = LOAD;
                    id_d       = gnt_idx;
                    s1_d       = gnt_idx ? req1_s1 : req0_s1;
                    s2_d       = gnt_idx ? req1_s2 : req0_s2;
                    load_cnt_d = 2'd0;
                    steps_d    = '0;
`ifdef NW_CTRL_TIMEOUT_EN
                    cyc_d      = '0;
                    to_d       = 1'b0;
`endif
                end
            end
            LOAD: begin
                steps_d = '0;
`ifdef NW_CTRL_TIMEOUT_EN
                cyc_d   = '0;
`endif
                if (load_cnt_q == LOAD_CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    load_cnt_d = load_cnt_q + 2'd1;
                end
            end
            RUN: begin
                if (trace_wen && (steps_q != STEPS_MAX)) begin
                    steps_d = steps_q + 1'b1;
                end
`ifdef NW_CTRL_TIMEOUT_EN
                cyc_d = cyc_q + 10'd1;
                if (grid_valid) begin
                    state_d = DONE;
                    to_d    = 1'b0;
                end else if (cyc_q == TIMEOUT_CNT) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                end
`else
                if (grid_valid) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Job state and captured result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            load_cnt_q <= 2'd0;
            steps_q    <= '0;
            id_q       <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
`ifdef NW_CTRL_TIMEOUT_EN
            cyc_q      <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            steps_q    <= steps_d;
            id_q       <= id_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
`ifdef NW_CTRL_TIMEOUT_EN
            cyc_q      <= cyc_d;
            to_q       <= to_d;
`endif
        end
    end

    // Ready is gated by reset so nothing is accepted while reset is held
    assign req0_ready = reset_n & gnt[0];
    assign req1_ready = reset_n & gnt[1];

    assign grid_reset = (state_q != RUN);
    assign grid_s1    = s1_q;
    assign grid_s2    = s2_q;
    assign res_valid  = (state_q == DONE);
    assign res_id     = id_q;
    assign res_steps  = steps_q;
`ifdef NW_CTRL_TIMEOUT_EN
    assign res_timeout = to_q;
`else
    assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nw_grid_ctrl.sv
// Self-checking bench for nw_grid_ctrl: table vectors, randomized jobs
// against a round-robin/step-count model, reset and timeout sequences.
// The timeout sequence is built only when NW_CTRL_TIMEOUT_EN is defined.
module tb_nw_grid_ctrl;

    localparam int LENGTH      = 10;
    localparam int CWIDTH      = 2;
    localparam int CORD_LENGTH = 8;
    localparam int TIMEOUT     = 1023;
    localparam int SW          = LENGTH * CWIDTH;
    localparam int STEP_MAX    = (1 << (CORD_LENGTH + 1)) - 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 req0_valid, req1_valid;
    logic                 req0_ready, req1_ready;
    logic [SW-1:0]        req0_s1, req0_s2, req1_s1, req1_s2;
    logic                 grid_reset;
    logic [SW-1:0]        grid_s1, grid_s2;
    logic                 grid_valid, trace_wen;
    logic                 res_valid, res_ready, res_id, res_timeout;
    logic [CORD_LENGTH:0] res_steps;

    int checkCount = 0;
    int passCount  = 0;
    int lastGrant  = 1;

    typedef struct {
        bit r0;
        bit r1;
        int nsteps;
        bit fin;
        int hold;
        bit gaps;
        bit same;
        int expId;
        int expSteps;
    } vec_t;

    vec_t vecs[9];

    nw_grid_ctrl #(
        .LENGTH      (LENGTH),
        .CWIDTH      (CWIDTH),
        .CORD_LENGTH (CORD_LENGTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .req0_ready  (req0_ready),
        .req1_ready  (req1_ready),
        .req0_s1     (req0_s1),
        .req0_s2     (req0_s2),
        .req1_s1     (req1_s1),
        .req1_s2     (req1_s2),
        .grid_reset  (grid_reset),
        .grid_s1     (grid_s1),
        .grid_s2     (grid_s2),
        .grid_valid  (grid_valid),
        .trace_wen   (trace_wen),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_steps   (res_steps),
        .res_timeout (res_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Round-robin reference: the last winner yields when both ask
    function automatic int modelGrant(input bit r0, input bit r1);
        int g;
        if (r0 && r1) g = 1 - lastGrant;
        else g = r0 ? 0 : 1;
        lastGrant = g;
        return g;
    endfunction

    function automatic int modelSteps(input int n);
        return (n > STEP_MAX) ? STEP_MAX : n;
    endfunction

    // Runs one complete job; called with inputs changeable (between edges)
    task automatic applyStimulus(input string tag, input bit r0, input bit r1, input int nsteps,
                                 input bit fin, input int hold, input bit gaps, input bit sameStr,
                                 input int expId, input int expSteps);
        int unsigned t;
        logic [SW-1:0] a0, b0, a1, b1, e1, e2;
        int waitN, loadCycles, readies, gid;
        bit granted, stable;
        t = $urandom; a0 = t[SW-1:0];
        t = $urandom; b0 = sameStr ? a0 : t[SW-1:0];
        t = $urandom; a1 = t[SW-1:0];
        t = $urandom; b1 = sameStr ? a1 : t[SW-1:0];
        req0_s1 = a0; req0_s2 = b0; req1_s1 = a1; req1_s2 = b1;
        req0_valid = r0; req1_valid = r1;
        granted = 1'b0; waitN = 0;
        #1;
        while (!granted && waitN < 50) begin
            if (req0_ready || req1_ready) granted = 1'b1;
            else begin @(negedge clk); #1; waitN++; end
        end
        checkOutput({tag, " grant seen"}, longint'(granted), 1);
        if (!granted) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        checkOutput({tag, " one ready"}, longint'(req0_ready & req1_ready), 0);
        gid = req1_ready ? 1 : 0;
        checkOutput({tag, " grant id"}, gid, expId);
        e1 = gid ? a1 : a0;
        e2 = gid ? b1 : b0;
        loadCycles = 0; readies = 0; waitN = 0;
        do begin
            @(negedge clk); #1; waitN++;
            if (req0_ready || req1_ready) readies++;
            if (grid_reset) loadCycles++;
        end while (grid_reset && waitN < 10);
        checkOutput({tag, " load cycles"}, loadCycles, 2);
        checkOutput({tag, " grid_s1"}, longint'(grid_s1), longint'(e1));
        checkOutput({tag, " grid_s2"}, longint'(grid_s2), longint'(e2));
        for (int i = 0; i < nsteps; i++) begin
            trace_wen  = 1'b1;
            grid_valid = fin && (i == nsteps - 1);
            @(negedge clk);
            if (!grid_valid) begin
                if (req0_ready || req1_ready) readies++;
                if (gaps && ($urandom_range(0, 2) == 0)) begin
                    trace_wen = 1'b0;
                    @(negedge clk);
                end
            end
        end
        if (!(fin && nsteps > 0)) begin
            trace_wen  = 1'b0;
            grid_valid = 1'b1;
            @(negedge clk);
        end
        trace_wen = 1'b0; grid_valid = 1'b0;
        #1;
        checkOutput({tag, " res_valid"}, longint'(res_valid), 1);
        checkOutput({tag, " res_id"}, longint'(res_id), expId);
        checkOutput({tag, " res_steps"}, longint'(res_steps), expSteps);
        checkOutput({tag, " res_timeout"}, longint'(res_timeout), 0);
        checkOutput({tag, " grid_reset in done"}, longint'(grid_reset), 1);
        if (req0_ready || req1_ready) readies++;
        checkOutput({tag, " no ready while busy"}, readies, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            stable = res_valid && (int'(res_id) == expId) && (int'(res_steps) == expSteps)
                     && !res_timeout && !req0_ready && !req1_ready;
            checkOutput($sformatf("%s hold %0d", tag, h), longint'(stable), 1);
        end
        res_ready = 1'b1;
        #1;
        checkOutput({tag, " no ready on ack"}, longint'(req0_ready | req1_ready), 0);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checkOutput({tag, " res_valid cleared"}, longint'(res_valid), 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " grid_reset"}, longint'(grid_reset), 1);
        checkOutput({tag, " ready"}, longint'(req0_ready | req1_ready), 0);
        checkOutput({tag, " res_valid"}, longint'(res_valid), 0);
        checkOutput({tag, " res_id"}, longint'(res_id), 0);
        checkOutput({tag, " res_steps"}, longint'(res_steps), 0);
        checkOutput({tag, " res_timeout"}, longint'(res_timeout), 0);
        checkOutput({tag, " grid_s"}, longint'(grid_s1 | grid_s2), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_s1 = '0; req0_s2 = '0; req1_s1 = '0; req1_s2 = '0;
        grid_valid = 1'b0; trace_wen = 1'b0; res_ready = 1'b0;

        vecs[0] = '{r0: 1, r1: 0, nsteps: 10,  fin: 1, hold: 0,  gaps: 0, same: 1, expId: 0, expSteps: 10};
        vecs[1] = '{r0: 1, r1: 1, nsteps: 4,   fin: 1, hold: 0,  gaps: 0, same: 0, expId: 1, expSteps: 4};
        vecs[2] = '{r0: 1, r1: 1, nsteps: 0,   fin: 0, hold: 1,  gaps: 0, same: 0, expId: 0, expSteps: 0};
        vecs[3] = '{r0: 1, r1: 1, nsteps: 7,   fin: 0, hold: 2,  gaps: 1, same: 0, expId: 1, expSteps: 7};
        vecs[4] = '{r0: 1, r1: 1, nsteps: 1,   fin: 1, hold: 0,  gaps: 0, same: 0, expId: 0, expSteps: 1};
        vecs[5] = '{r0: 0, r1: 1, nsteps: 0,   fin: 0, hold: 0,  gaps: 0, same: 0, expId: 1, expSteps: 0};
        vecs[6] = '{r0: 1, r1: 0, nsteps: 3,   fin: 0, hold: 20, gaps: 0, same: 0, expId: 0, expSteps: 3};
        vecs[7] = '{r0: 0, r1: 1, nsteps: 520, fin: 1, hold: 0,  gaps: 0, same: 0, expId: 1, expSteps: STEP_MAX};
        vecs[8] = '{r0: 1, r1: 1, nsteps: 2,   fin: 1, hold: 1,  gaps: 0, same: 0, expId: 0, expSteps: 2};

        repeat (2) @(negedge clk);
        #1;
        checkResetValues("reset");
        req0_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            applyStimulus($sformatf("vec%0d", v), vecs[v].r0, vecs[v].r1, vecs[v].nsteps,
                          vecs[v].fin, vecs[v].hold, vecs[v].gaps, vecs[v].same,
                          vecs[v].expId, vecs[v].expSteps);
        end
        lastGrant = vecs[8].expId;

        for (int k = 0; k < 20; k++) begin
            bit r0, r1, fin;
            int n, id;
            do begin
                r0 = ($urandom_range(0, 1) == 1);
                r1 = ($urandom_range(0, 1) == 1);
            end while (!r0 && !r1);
            n   = $urandom_range(0, 30);
            fin = ($urandom_range(0, 1) == 1);
            id  = modelGrant(r0, r1);
            applyStimulus($sformatf("rnd%0d", k), r0, r1, n, fin, $urandom_range(0, 3),
                          1'b1, 1'b0, id, modelSteps(n));
        end

        // Reset in the middle of RUN abandons the job
        req0_valid = 1'b1; req1_valid = 1'b1;
        begin
            int waitN;
            waitN = 0;
            #1;
            while (grid_reset && waitN < 20) begin @(negedge clk); #1; waitN++; end
            checkOutput("midreset reached run", longint'(grid_reset), 0);
            trace_wen = 1'b1;
            repeat (3) @(negedge clk);
            trace_wen = 1'b0;
            #3;
            reset_n = 1'b0;
            #1;
            checkResetValues("midreset");
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            waitN = 0;
            repeat (5) begin
                @(negedge clk); #1;
                if (res_valid || req0_ready || req1_ready) waitN++;
            end
            checkOutput("midreset no result", waitN, 0);
        end
        lastGrant = 1;

        // Both requesters held after reset alternate starting with 0
        applyStimulus("alt0", 1'b1, 1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 0, 5);
        applyStimulus("alt1", 1'b1, 1'b1, 6, 1'b0, 0, 1'b0, 1'b0, 1, 6);
        applyStimulus("alt2", 1'b1, 1'b1, 2, 1'b1, 0, 1'b0, 1'b0, 0, 2);
        applyStimulus("alt3", 1'b1, 1'b1, 9, 1'b1, 0, 1'b0, 1'b0, 1, 9);
        req0_valid = 1'b0; req1_valid = 1'b0;
        lastGrant = 1;

`ifdef NW_CTRL_TIMEOUT_EN
        // A grid that never completes is aborted after TIMEOUT+1 RUN cycles
        begin
            int waitN, runCycles;
            @(negedge clk);
            req0_valid = 1'b1;
            #1;
            waitN = 0;
            while (!req0_ready && waitN < 20) begin @(negedge clk); #1; waitN++; end
            checkOutput("timeout grant", longint'(req0_ready), 1);
            void'(modelGrant(1'b1, 1'b0));
            waitN = 0;
            do begin @(negedge clk); #1; waitN++; end while (grid_reset && waitN < 10);
            checkOutput("timeout load cycles", waitN, 3);
            runCycles = 0;
            while (!res_valid && runCycles < TIMEOUT + 20) begin
                runCycles++;
                trace_wen = (runCycles <= 5);
                @(negedge clk); #1;
            end
            trace_wen = 1'b0;
            checkOutput("timeout run cycles", runCycles, TIMEOUT + 1);
            checkOutput("timeout flag", longint'(res_timeout), 1);
            checkOutput("timeout steps", longint'(res_steps), 5);
            req0_valid = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            #1;
            checkOutput("timeout res_valid cleared", longint'(res_valid), 0);
        end
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/nw_grid_ctrl.md
NW_GRID_CTRL -- requirements
Module: nw_grid_ctrl

Interface
REQ-001 The block SHALL have parameter LENGTH, default 10: characters per string.
REQ-002 The block SHALL have parameter CWIDTH, default 2: bits per character.
REQ-003 The block SHALL have parameter CORD_LENGTH, default 8: bits per trace coordinate.
REQ-004 The block SHALL have parameter TIMEOUT, default 1023: maximum RUN cycles, 10-bit counter.
REQ-005 The block SHALL have port clk, input, 1: the single clock.
REQ-006 The block SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 The block SHALL have ports req0_valid and req1_valid, input, 1: job request.
REQ-008 The block SHALL have ports req0_ready and req1_ready, output, 1: job accepted this cycle.
REQ-009 The block SHALL have ports req0_s1, req0_s2, req1_s1 and req1_s2, input, LENGTH*CWIDTH: job strings.
REQ-010 The block SHALL have port grid_reset, output, 1: active-high reset to the alignment grid.
REQ-011 The block SHALL have ports grid_s1 and grid_s2, output, LENGTH*CWIDTH: registered strings to the grid.
REQ-012 The block SHALL have port grid_valid, input, 1: grid traceback complete.
REQ-013 The block SHALL have port trace_wen, input, 1: grid writes one {x,y} traceback step.
REQ-014 The block SHALL have port res_valid, output, 1: result available.
REQ-015 The block SHALL have port res_ready, input, 1: result consumed.
REQ-016 The block SHALL have port res_id, output, 1: requester index of the result.
REQ-017 The block SHALL have port res_steps, output, CORD_LENGTH+1: traceback step count.
REQ-018 The block SHALL have port res_timeout, output, 1: job aborted by timeout.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-020 In IDLE with any reqN_valid, the block SHALL grant one requester round-robin (the last granted index has lowest priority), pulse its reqN_ready for 1 cycle, capture its strings into grid_s1/grid_s2 and the index into res_id, and go to LOAD.
REQ-021 At most one reqN_ready SHALL be high in any cycle, and only in IDLE.
REQ-022 LOAD SHALL hold grid_reset=1 for exactly 2 cycles, clear the step and cycle counters, then enter RUN.
REQ-023 In RUN, grid_reset SHALL be 0, res_steps SHALL increment on each trace_wen (saturating at all-ones), and the cycle counter SHALL increment every cycle.
REQ-024 In RUN, grid_valid=1 SHALL move the FSM to DONE with res_timeout=0; a trace_wen in the same cycle SHALL still be counted.
REQ-025 res_valid SHALL be 1 only in DONE, and res_id, res_steps and res_timeout SHALL be stable while res_valid=1.
REQ-026 DONE with res_ready=1 SHALL return to IDLE the next cycle and set grid_reset=1; no request SHALL be granted in that same cycle.
REQ-027 grid_reset SHALL be 1 in IDLE, LOAD and DONE.
REQ-028 Requests arriving outside IDLE SHALL be held off (ready=0), not dropped.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, grid_reset=1, req*_ready=0, res_valid=0, res_id=0, res_steps=0, res_timeout=0, grid_s1/grid_s2=0, cycle counter=0, and last-grant=1 (so requester 0 wins first).
REQ-030 Reset asserted mid-job SHALL abandon the job with no result produced.

Configuration
REQ-031 When NW_CTRL_TIMEOUT_EN is defined, RUN with the cycle counter equal to TIMEOUT and grid_valid=0 SHALL go to DONE with res_timeout=1 and res_steps as counted.
REQ-032 When NW_CTRL_TIMEOUT_EN is undefined, RUN SHALL wait indefinitely for grid_valid, res_timeout SHALL be tied to 0, and no cycle counter SHALL be synthesized.

Structure
REQ-033 Package nw_pkg SHALL hold the FSM state typedef, the TOP/LEFT/CORNER direction codes (00/01/10), and the LOAD_CYCLES=2 constant.
REQ-034 Round-robin grant logic SHALL be the sub-module nw_rr_arb (2 requesters, registered last-grant).

Verification
REQ-035 Apply reset, then req0_valid=1 with identical strings (LENGTH=10); the bench SHALL see req0_ready for 1 cycle, grid_reset high for 2 cycles, res_valid with res_id=0, res_steps=10, res_timeout=0.
REQ-036 Hold req0_valid and req1_valid continuously over 4 jobs; the bench SHALL see grants in the order 0,1,0,1.
REQ-037 Hold res_ready=0 for 20 cycles in DONE; the bench SHALL see res_valid and all result fields held constant and no reqN_ready.
REQ-038 With NW_CTRL_TIMEOUT_EN defined and grid_valid never asserted, the bench SHALL see res_valid with res_timeout=1 after 2 LOAD cycles plus TIMEOUT+1 RUN cycles.
REQ-039 Assert reset_n=0 during RUN; the bench SHALL see IDLE and all outputs at reset values immediately with no clock edge, and no res_valid afterwards.
REQ-040 Assert grid_valid and trace_wen in the same cycle; the bench SHALL see that final step included in res_steps.
